// File: rtl/cqu_mips_defs.sv
// Shared definitions for the next-PC generator: FSM encodings, PC increment,
// stall-vector index and the default reset vector.
package cqu_mips_defs;

  typedef enum logic [1:0] {
    PCG_RUN        = 2'd0,
    PCG_PEND_BR    = 2'd1,
    PCG_PEND_FLUSH = 2'd2
  } pcg_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam int          STALL_IF         = 0;
  localparam logic [31:0] PCG_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_next_gen_if.sv
// Fetch-side bundle of the next-PC generator: stall, current PC, redirect
// requests in; next PC, pending flag and fetch-address-error report out.
interface pc_next_gen_if;
  logic [5:0]  stall;
  logic [31:0] pc_cur;
  logic        br_valid;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_target;
  logic [31:0] pc_next;
  logic        redirect_pending;
  logic        fetch_adel;
  logic [31:0] adel_vaddr;

  modport master (
    output stall, pc_cur, br_valid, br_target, flush, flush_target,
    input  pc_next, redirect_pending, fetch_adel, adel_vaddr
  );

  modport slave (
    input  stall, pc_cur, br_valid, br_target, flush, flush_target,
    output pc_next, redirect_pending, fetch_adel, adel_vaddr
  );
endinterface

// File: rtl/pc_next_gen.sv
// Next-PC generator: priority mux (flush > pending flush > branch > pending
// branch > pc+4) plus a small FSM that parks redirects arriving during stalls.
module pc_next_gen
  import cqu_mips_defs::*;
#(
  parameter logic [31:0] RESET_VECTOR = PCG_RESET_VECTOR,
  parameter bit          ALIGN_CHECK  = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  pc_next_gen_if.slave bus
);

  // The fetch stage owns the PC register; a misaligned vector is a build error.
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_vector_check
    $error("pc_next_gen: RESET_VECTOR must be word aligned");
  end

  pcg_state_e  state_reg;
  logic [31:0] pend_target_reg;
  logic        pending_reg;
  logic        adel_reg;
  logic [31:0] adel_vaddr_reg;

  logic        accept;
  logic [31:0] pc_seq;
  logic [31:0] pc_next;
  logic        next_misaligned;
  logic        unused_stall_bits;

  assign accept            = !bus.stall[STALL_IF];
  assign pc_seq            = bus.pc_cur + PC_INC;
  assign next_misaligned   = ALIGN_CHECK && (pc_next[1:0] != 2'b00);
  assign unused_stall_bits = ^bus.stall[5:1];

  always_comb begin
    pc_next = pc_seq;
    if (bus.flush) begin
      pc_next = bus.flush_target;
    end else if (state_reg == PCG_PEND_FLUSH) begin
      pc_next = pend_target_reg;
    end else if (bus.br_valid && state_reg == PCG_RUN) begin
      pc_next = bus.br_target;
    end else if (state_reg == PCG_PEND_BR) begin
      pc_next = pend_target_reg;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= PCG_RUN;
      pend_target_reg <= 32'h0;
      pending_reg     <= 1'b0;
      adel_reg        <= 1'b0;
      adel_vaddr_reg  <= 32'h0;
    end else if (accept) begin
      state_reg   <= PCG_RUN;
      pending_reg <= 1'b0;
      adel_reg    <= next_misaligned;
      if (next_misaligned) begin
        adel_vaddr_reg <= pc_next;
      end
    end else if (bus.flush) begin
      // A newer flush always replaces whatever was parked; the faulting fetch is squashed.
      state_reg       <= PCG_PEND_FLUSH;
      pend_target_reg <= bus.flush_target;
      pending_reg     <= 1'b1;
      adel_reg        <= 1'b0;
    end else if (bus.br_valid && state_reg == PCG_RUN) begin
      state_reg       <= PCG_PEND_BR;
      pend_target_reg <= bus.br_target;
      pending_reg     <= 1'b1;
    end
  end

  assign bus.pc_next          = pc_next;
  assign bus.redirect_pending = pending_reg;
  assign bus.fetch_adel       = adel_reg;
  assign bus.adel_vaddr       = adel_vaddr_reg;

endmodule

// File: tb/tb_pc_next_gen.sv
// Self-checking bench for pc_next_gen: directed scenarios then random traffic,
// two instances (alignment check on/off) against a queue-based redirect model.
module tb_pc_next_gen;

  logic        clk;
  logic        rstn;
  logic [5:0]  stall;
  logic [31:0] pc_cur;
  logic        br_valid;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_target;

  int total;
  int bad;

  pc_next_gen_if ifa ();
  pc_next_gen_if ifb ();

  assign ifa.stall = stall;       assign ifb.stall = stall;
  assign ifa.pc_cur = pc_cur;     assign ifb.pc_cur = pc_cur;
  assign ifa.br_valid = br_valid; assign ifb.br_valid = br_valid;
  assign ifa.br_target = br_target;       assign ifb.br_target = br_target;
  assign ifa.flush = flush;               assign ifb.flush = flush;
  assign ifa.flush_target = flush_target; assign ifb.flush_target = flush_target;

  pc_next_gen #(.RESET_VECTOR(32'h0), .ALIGN_CHECK(1'b1)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa.slave));
  pc_next_gen #(.RESET_VECTOR(32'h0), .ALIGN_CHECK(1'b0)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: at most one parked redirect, kept as a queue entry.
  typedef struct {
    bit          is_flush;
    logic [31:0] target;
  } redir_t;

  redir_t      pend_q[$];
  logic        m_adel;
  logic [31:0] m_vaddr;

  function automatic logic [31:0] model_pc_next();
    if (flush) return flush_target;
    if (pend_q.size() != 0 && pend_q[0].is_flush) return pend_q[0].target;
    if (br_valid && pend_q.size() == 0) return br_target;
    if (pend_q.size() != 0) return pend_q[0].target;
    return pc_cur + 32'd4;
  endfunction

  task automatic model_clock(input logic [31:0] taken);
    redir_t r;
    if (!stall[0]) begin
      pend_q.delete();
      m_adel = (taken % 4) != 0;
      if (m_adel) m_vaddr = taken;
    end else if (flush) begin
      pend_q.delete();
      r.is_flush = 1'b1;
      r.target   = flush_target;
      pend_q.push_back(r);
      m_adel = 1'b0;
    end else if (br_valid && pend_q.size() == 0) begin
      r.is_flush = 1'b0;
      r.target   = br_target;
      pend_q.push_back(r);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] exp_next);
    logic [31:0] exp_pend;
    exp_pend = (pend_q.size() != 0) ? 32'd1 : 32'd0;
    check({tag, ".a.pc_next"}, ifa.pc_next, exp_next);
    check({tag, ".a.pending"}, {31'd0, ifa.redirect_pending}, exp_pend);
    check({tag, ".a.adel"}, {31'd0, ifa.fetch_adel}, {31'd0, m_adel});
    check({tag, ".a.vaddr"}, ifa.adel_vaddr, m_vaddr);
    check({tag, ".b.pc_next"}, ifb.pc_next, exp_next);
    check({tag, ".b.pending"}, {31'd0, ifb.redirect_pending}, exp_pend);
    check({tag, ".b.adel"}, {31'd0, ifb.fetch_adel}, 32'd0);
    check({tag, ".b.vaddr"}, ifb.adel_vaddr, 32'd0);
  endtask

  // One cycle: check outputs, clock, then act as the fetch stage.
  task automatic step(input string tag);
    logic [31:0] exp_next;
    #1;
    exp_next = model_pc_next();
    check_all(tag, exp_next);
    $display("step %-10s stall=%0d br=%0d/%h fl=%0d/%h pc_cur=%h pc_next=%h pend=%0d adel=%0d",
             tag, stall[0], br_valid, br_target, flush, flush_target, pc_cur,
             ifa.pc_next, ifa.redirect_pending, ifa.fetch_adel);
    @(posedge clk);
    model_clock(exp_next);
    #1;
    if (!stall[0]) pc_cur = exp_next;
  endtask

  task automatic idle_inputs();
    stall = 6'd0; br_valid = 1'b0; flush = 1'b0;
    br_target = 32'h0; flush_target = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pend_q.delete();
    m_adel  = 1'b0;
    m_vaddr = 32'h0;
    idle_inputs();
    pc_cur = 32'h0;
    rstn   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all("reset", 32'h4);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Free-run sequential fetch
    repeat (3) step("seq");

    // Taken branch with no stall: zero-latency redirect
    pc_cur = 32'h10; br_valid = 1'b1; br_target = 32'h40;
    step("br_run");
    br_valid = 1'b0;
    step("after_br");

    // Branch arriving during a stall is parked and replayed on release
    stall = 6'h3f; br_valid = 1'b1; br_target = 32'h80;
    step("br_stall");
    br_valid = 1'b0; stall = 6'h01;
    repeat (3) step("hold_br");
    stall = 6'h3e;
    step("release");
    step("post_rel");

    // Flush overrides a parked branch; later wrong-path branch discarded
    stall = 6'h01; br_valid = 1'b1; br_target = 32'h80;
    step("br_park");
    br_valid = 1'b0; flush = 1'b1; flush_target = 32'hBFC0_0380;
    step("flush_ovr");
    flush = 1'b0; br_valid = 1'b1; br_target = 32'h100;
    step("wrong_br");
    br_valid = 1'b0; stall = 6'h00;
    step("fl_rel");
    step("post_fl");

    // Misaligned fetch address, then an aligned redirect clears it
    br_valid = 1'b1; br_target = 32'h42;
    step("mis_br");
    br_target = 32'h100;
    step("align_br");
    br_valid = 1'b0;
    step("adel_clr");

    // Both flush and branch together: flush wins
    br_valid = 1'b1; br_target = 32'h200; flush = 1'b1; flush_target = 32'h300;
    step("fl_and_br");
    stall = 6'h01;
    step("fl_br_stl");
    idle_inputs();
    step("fl_br_rel");

    // 32-bit wrap of the sequential increment
    pc_cur = 32'hFFFF_FFFC;
    step("wrap");

    // Asynchronous reset while a branch is parked
    stall = 6'h01; br_valid = 1'b1; br_target = 32'h500;
    step("pre_rst");
    #2;
    rstn = 1'b0;
    pc_cur = 32'h0;
    pend_q.delete();
    m_adel = 1'b0;
    m_vaddr = 32'h0;
    #1;
    check({"async_rst", ".a.pending"}, {31'd0, ifa.redirect_pending}, 32'd0);
    check({"async_rst", ".b.pending"}, {31'd0, ifb.redirect_pending}, 32'd0);
    idle_inputs();
    @(negedge clk);
    check_all("in_rst", 32'h4);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      stall        = {$urandom_range(0, 31), ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0};
      br_valid     = ($urandom_range(0, 99) < 30);
      br_target    = {$urandom_range(0, 32'h3FFF), (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00)};
      flush        = ($urandom_range(0, 99) < 10);
      flush_target = {$urandom_range(0, 32'h3FFF), (($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00)};
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
